// File: rtl/axis_src_pkg.sv
// Package for axis_pattern_source.
// Provides the FSM state type, the Galois LFSR tap constants for each
// supported data width, and a helper that picks the taps for a given width.
package axis_src_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  // Right-shift Galois LFSR taps (maximal length) per data width.
  localparam logic [7:0]  TAPS_8  = 8'hB8;
  localparam logic [15:0] TAPS_16 = 16'hB400;
  localparam logic [31:0] TAPS_32 = 32'h8020_0003;

  // Taps for the given width, zero-extended to 32 bits; unsupported
  // widths return zero and are rejected at elaboration by the top.
  function automatic logic [31:0] lfsr_taps(input int data_size);
    case (data_size)
      8:       return {24'd0, TAPS_8};
      16:      return {16'd0, TAPS_16};
      32:      return TAPS_32;
      default: return 32'd0;
    endcase
  endfunction

endpackage

// File: rtl/axis_src_pattern_gen.sv
// Combinational next-value generator for the pattern source.
// Ports:
//   value      in   DATA_SIZE  current beat value
//   mode       in   1          0 = increment, 1 = Galois right-shift LFSR
//   next_value out  DATA_SIZE  value of the following beat
module axis_src_pattern_gen
  import axis_src_pkg::*;
#(
  parameter int DATA_SIZE = 8
) (
  input  logic [DATA_SIZE-1:0] value,
  input  logic                 mode,
  output logic [DATA_SIZE-1:0] next_value
);

  localparam logic [31:0]          TAPS_ALL = lfsr_taps(DATA_SIZE);
  localparam logic [DATA_SIZE-1:0] TAPS     = TAPS_ALL[DATA_SIZE-1:0];

  always_comb begin
    if (mode) begin
      next_value = value[0] ? ((value >> 1) ^ TAPS) : (value >> 1);
    end else begin
      // Increment wraps naturally modulo 2**DATA_SIZE.
      next_value = value + DATA_SIZE'(1);
    end
  end

endmodule

// File: rtl/axis_pattern_source.sv
// AXI4-Stream pattern source (master). Emits a programmed run of beats
// carrying an incrementing or LFSR pattern, with optional idle gaps after
// each handshake. All outputs are registered; m_ready only feeds next-state
// logic, never an output directly.
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   start       1-cycle run request, honoured only while busy==0
//   length      beats in the run (0 = empty run, done pulse only)
//   seed        first beat value (0 is replaced by 1 in LFSR mode)
//   gap         idle cycles inserted after each non-final handshake
//   mode        0 = increment, 1 = LFSR
//   m_data, m_valid, m_ready  stream master signals
//   busy        run in progress
//   done        1-cycle pulse after the final handshake (or empty run)
//   beat_count  handshakes completed in the current/last run
module axis_pattern_source
  import axis_src_pkg::*;
#(
  parameter int DATA_SIZE = 8,
  parameter int LEN_W     = 16,
  parameter int GAP_W     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [LEN_W-1:0]     length,
  input  logic [DATA_SIZE-1:0] seed,
  input  logic [GAP_W-1:0]     gap,
  input  logic                 mode,
  output logic [DATA_SIZE-1:0] m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 busy,
  output logic                 done,
  output logic [LEN_W-1:0]     beat_count
);

  if (!(DATA_SIZE == 8 || DATA_SIZE == 16 || DATA_SIZE == 32)) begin : g_bad_width
    $error("axis_pattern_source: DATA_SIZE must be 8, 16 or 32");
  end

  state_t               state, state_n;
  logic [LEN_W-1:0]     len_q, len_n;
  logic [GAP_W-1:0]     gap_q, gap_n;
  logic [GAP_W-1:0]     gap_cnt, gap_cnt_n;
  logic                 mode_q, mode_n;
  logic [DATA_SIZE-1:0] m_data_n;
  logic                 m_valid_n, busy_n, done_n;
  logic [LEN_W-1:0]     beat_count_n;

  logic [DATA_SIZE-1:0] data_next;
  logic [DATA_SIZE-1:0] seed_fixed;
  logic                 handshake;
  logic                 last_beat;
  logic                 run_start;
  logic                 empty_start;

  axis_src_pattern_gen #(
    .DATA_SIZE (DATA_SIZE)
  ) u_gen (
    .value      (m_data),
    .mode       (mode_q),
    .next_value (data_next)
  );

  // The all-zero LFSR state never leaves itself, so a zero seed becomes 1.
  assign seed_fixed  = (mode && (seed == '0)) ? DATA_SIZE'(1) : seed;
  assign handshake   = m_valid & m_ready;
  assign last_beat   = (beat_count == len_q - LEN_W'(1));
  assign run_start   = (state == IDLE) && start && (length != '0);
  assign empty_start = (state == IDLE) && start && (length == '0);

  // State register.
  // NOTE: clocked state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default assignment first so no path leaves state_n unassigned,
    // which would otherwise infer a latch.
    state_n = state;
    case (state)
      IDLE: if (run_start) state_n = SEND;
      SEND: begin
        if (handshake) begin
          if (last_beat)          state_n = IDLE;
          else if (gap_q != '0)   state_n = GAP;
        end
      end
      GAP:  if (gap_cnt == GAP_W'(1)) state_n = SEND;
      default: state_n = IDLE;
    endcase
  end

  // Next values of the output and field registers.
  always_comb begin
    m_data_n     = m_data;
    m_valid_n    = m_valid;
    busy_n       = busy;
    done_n       = 1'b0;
    beat_count_n = beat_count;
    len_n        = len_q;
    gap_n        = gap_q;
    gap_cnt_n    = gap_cnt;
    mode_n       = mode_q;
    case (state)
      IDLE: begin
        if (run_start) begin
          m_data_n     = seed_fixed;
          m_valid_n    = 1'b1;
          busy_n       = 1'b1;
          beat_count_n = '0;
          len_n        = length;
          gap_n        = gap;
          mode_n       = mode;
        end else if (empty_start) begin
          done_n       = 1'b1;
          beat_count_n = '0;
        end
      end
      SEND: begin
        if (handshake) begin
          // Saturate at the latched length.
          if (beat_count < len_q) beat_count_n = beat_count + LEN_W'(1);
          if (last_beat) begin
            m_valid_n = 1'b0;
            busy_n    = 1'b0;
            done_n    = 1'b1;
          end else if (gap_q == '0) begin
            m_data_n = data_next;
          end else begin
            m_valid_n = 1'b0;
            gap_cnt_n = gap_q;
          end
        end
      end
      GAP: begin
        // m_data still holds the previous beat, so next() continues the run.
        if (gap_cnt == GAP_W'(1)) begin
          m_valid_n = 1'b1;
          m_data_n  = data_next;
        end else begin
          gap_cnt_n = gap_cnt - GAP_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_data     <= '0;
      m_valid    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      beat_count <= '0;
      len_q      <= '0;
      gap_q      <= '0;
      gap_cnt    <= '0;
      mode_q     <= 1'b0;
    end else begin
      m_data     <= m_data_n;
      m_valid    <= m_valid_n;
      busy       <= busy_n;
      done       <= done_n;
      beat_count <= beat_count_n;
      len_q      <= len_n;
      gap_q      <= gap_n;
      gap_cnt    <= gap_cnt_n;
      mode_q     <= mode_n;
    end
  end

endmodule
